// File: rtl/mux_8in_16bits.sv
// mux_8in_16bits: 8:1 16-bit selector with combinational result and registered copy plus select echo.
module mux_8in_16bits #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [SEL_W-1:0] select,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q,
  output logic [SEL_W-1:0] sel_q
);
  logic [WIDTH-1:0] r_d;
  logic [SEL_W-1:0] sel_d;
  always_comb begin
    r = a;
    case (select)
      3'd0: r = a;
      3'd1: r = b;
      3'd2: r = c;
      3'd3: r = d;
      3'd4: r = e;
      3'd5: r = f;
      3'd6: r = g;
      3'd7: r = h;
    endcase
    r_d   = r;
    sel_d = select;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      sel_q <= '0;
    end else begin
      r_q   <= r_d;
      sel_q <= sel_d;
    end
  end
endmodule

// File: tb/tb_mux_8in_16bits.sv
// tb_mux_8in_16bits: directed vectors against an array-indexed model, checked every falling clock edge.
module tb_mux_8in_16bits;
  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [2:0]  select;
  logic [15:0] r, r_q;
  logic [2:0]  sel_q;
  int          errors = 0;
  int          checks = 0;
  logic        chk_en = 1'b0;
  logic [15:0] m_rq = '0;
  logic [2:0]  m_sq = '0;

  mux_8in_16bits dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .select(select), .r(r), .r_q(r_q), .sel_q(sel_q)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  function automatic logic [15:0] pick(input logic [2:0] s);
    logic [15:0] src [8];
    src = '{a, b, c, d, e, f, g, h};
    return src[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rq = '0;
      m_sq = '0;
    end else begin
      m_rq = pick(select);
      m_sq = select;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_r", r, pick(select));
      check("cmp_r_q", r_q, m_rq);
      check("cmp_sel_q", {13'd0, sel_q}, {13'd0, m_sq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_tab [8];
    exp_tab = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h7890, 16'h8901};
    rst_n = 1'b0;
    {a, b, c, d, e, f, g, h} = {16'h1234, 16'h2345, 16'h3456, 16'h4567,
                                16'h5678, 16'h6789, 16'h7890, 16'h8901};
    select = 3'd0;
    for (int i = 0; i < 8; i++) begin
      select = 3'(i);
      #10;
      check($sformatf("noclk_r_sel%0d", i), r, exp_tab[i]);
    end
    check("reset_r_q", r_q, 16'h0000);
    check("reset_sel_q", {13'd0, sel_q}, 16'h0000);
    select = 3'd0;
    clk_en = 1'b1;
    chk_en = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      select = 3'(i);
      tick();
    end
    check("sweep_r_q_7", r_q, 16'h8901);
    check("sweep_sel_q_7", {13'd0, sel_q}, 16'h0007);
    select = 3'd5;
    f = 16'hABCD;
    #1 check("f_change_r", r, 16'hABCD);
    tick();
    check("f_change_r_q", r_q, 16'hABCD);
    f = 16'h6789;
    select = 3'd3;
    tick();
    #2 check("pre_reset_r_q", r_q, 16'h4567);
    rst_n = 1'b0;
    #1;
    check("async_reset_r_q", r_q, 16'h0000);
    check("async_reset_sel_q", {13'd0, sel_q}, 16'h0000);
    check("async_reset_r", r, 16'h4567);
    tick();
    select = 3'd7;
    #2 rst_n = 1'b1;
    #1 check("release_hold_r_q", r_q, 16'h0000);
    tick();
    check("release_load_r_q", r_q, 16'h8901);
    check("release_load_sel_q", {13'd0, sel_q}, 16'h0007);
    {a, b, c, d, e, f, g, h} = {16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                16'h0010, 16'h0020, 16'h0040, 16'h0080};
    for (int i = 0; i < 8; i++) begin
      select = 3'(i);
      #1 check($sformatf("walk_r_sel%0d", i), r, 16'h0001 << i);
      tick();
    end
    check("walk_r_q_last", r_q, 16'h0080);
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
